instr_fetch_unit: RTL and testbench

//  Instruction fetch stage feeding the 4-bit core's instruction_bus. Holds the program counter, requests 12-bit words

---
 rtl/instr_fetch_unit.sv | 204 ++++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : Instruction fetch stage for the 4-bit core. Holds the fetch PC,
//            fetches 12-bit words from program flash over a req/ack handshake,
//            buffers them as {pc, word} and presents the head of the buffer
//            to the decoder with a valid/ready handshake. Jump redirects
//            flush the buffer and discard any stale in-flight word.
// Config   : IFU_PREFETCH_EN defined   -> 2-entry buffer, prefetch while the
//                                         core stalls.
//            IFU_PREFETCH_EN undefined -> 1-entry buffer, next fetch only
//                                         once the head retires.
// Ports    : clk, rst                    clock / sync active-high reset
//            flash_req, flash_addr       fetch request and address (out)
//            flash_ack, flash_data       flash response strobe and word (in)
//            instruction_bus, instr_valid,
//            pc_out                      head instruction to the core (out)
//            instr_ready                 core accepts head instruction (in)
//            jmp_en, jmp_target          redirect strobe and address (in)
// Revision : 1.0  initial release
// ============================================================================
module instr_fetch_unit #(
    parameter int              PC_W     = 8,
    parameter int              INSTR_W  = 12,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               flash_req,
    output logic [PC_W-1:0]    flash_addr,
    input  logic               flash_ack,
    input  logic [INSTR_W-1:0] flash_data,
    output logic [INSTR_W-1:0] instruction_bus,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [PC_W-1:0]    pc_out,
    input  logic               jmp_en,
    input  logic [PC_W-1:0]    jmp_target
);

`ifdef IFU_PREFETCH_EN
    localparam int c_DEPTH = 2;
`else
    localparam int c_DEPTH = 1;
`endif

    localparam logic [1:0] c_DEPTH_CNT = 2'(c_DEPTH);
    localparam logic [PC_W-1:0] c_PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    // FSM encoding
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_FETCH = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [PC_W-1:0]    r_addr;     // address of current / next fetch
    logic [PC_W-1:0]    r_jmp_pc;   // redirect target held while draining
    logic [1:0]         r_count;    // buffered words
    logic [PC_W-1:0]    r_pc   [c_DEPTH];
    logic [INSTR_W-1:0] r_word [c_DEPTH];

    logic [1:0]         w_state_nxt;
    logic [PC_W-1:0]    w_addr_nxt;
    logic [PC_W-1:0]    w_jmp_pc_nxt;
    logic [1:0]         w_count_nxt;
    logic               w_pop;
    logic               w_ack;
    logic               w_push;
    logic [1:0]         w_after_pop;

    // ------------------------------------------------------------------
    // Buffer bookkeeping
    // ------------------------------------------------------------------
    assign w_pop       = (r_count != 2'd0) & instr_ready;
    // An ack only means something while a request is actually out.
    assign w_ack       = flash_ack & (r_state != c_ST_IDLE);
    assign w_after_pop = r_count - {1'b0, w_pop};
    // Words acked during DRAIN, or in the same cycle as a jump, are stale.
    assign w_push      = w_ack & (r_state == c_ST_FETCH) & ~jmp_en &
                         (w_after_pop < c_DEPTH_CNT);
    // A jump flushes everything, including a head retiring this cycle.
    assign w_count_nxt = jmp_en ? 2'd0 : (w_after_pop + {1'b0, w_push});

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_addr_nxt   = r_addr;
        w_jmp_pc_nxt = r_jmp_pc;

        case (r_state)
            c_ST_IDLE: begin
                if (jmp_en) begin
                    w_addr_nxt = jmp_target;
                end
                // A free slot (also after a flush) restarts fetching.
                if (w_count_nxt < c_DEPTH_CNT) begin
                    w_state_nxt = c_ST_FETCH;
                end
            end

            c_ST_FETCH: begin
                if (w_ack) begin
                    if (jmp_en) begin
                        w_addr_nxt  = jmp_target;
                        w_state_nxt = c_ST_FETCH;
                    end else begin
                        w_addr_nxt  = r_addr + c_PC_ONE;
                        // The next request occupies a slot, so only keep
                        // fetching if the buffer still has room for it.
                        w_state_nxt = (w_count_nxt < c_DEPTH_CNT) ?
                                      c_ST_FETCH : c_ST_IDLE;
                    end
                end else if (jmp_en) begin
                    // Request must complete at the old address; its word
                    // is thrown away.
                    w_jmp_pc_nxt = jmp_target;
                    w_state_nxt  = c_ST_DRAIN;
                end
            end

            c_ST_DRAIN: begin
                if (jmp_en) begin
                    w_jmp_pc_nxt = jmp_target;
                end
                if (w_ack) begin
                    w_addr_nxt  = jmp_en ? jmp_target : r_jmp_pc;
                    w_state_nxt = c_ST_FETCH;
                end
            end

            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_addr   <= RESET_PC;
            r_jmp_pc <= RESET_PC;
            r_count  <= 2'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_addr   <= w_addr_nxt;
            r_jmp_pc <= w_jmp_pc_nxt;
            r_count  <= w_count_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Buffer storage: slot 0 is the head; a pop shifts the rest down and
    // the new word lands just after the surviving entries.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < c_DEPTH; gi++) begin : g_slot
            if (gi < c_DEPTH - 1) begin : g_shift
                always_ff @(posedge clk) begin
                    if (rst) begin
                        r_pc[gi]   <= RESET_PC;
                        r_word[gi] <= '0;
                    end else begin
                        if (w_pop) begin
                            r_pc[gi]   <= r_pc[gi+1];
                            r_word[gi] <= r_word[gi+1];
                        end
                        if (w_push && (w_after_pop == 2'(gi))) begin
                            r_pc[gi]   <= r_addr;
                            r_word[gi] <= flash_data;
                        end
                    end
                end
            end else begin : g_last
                always_ff @(posedge clk) begin
                    if (rst) begin
                        r_pc[gi]   <= RESET_PC;
                        r_word[gi] <= '0;
                    end else if (w_push && (w_after_pop == 2'(gi))) begin
                        r_pc[gi]   <= r_addr;
                        r_word[gi] <= flash_data;
                    end
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign flash_req       = (r_state != c_ST_IDLE);
    assign flash_addr      = r_addr;
    assign instr_valid     = (r_count != 2'd0);
    assign instruction_bus = instr_valid ? r_word[0] : '0;
    assign pc_out          = r_pc[0];

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Purpose  : Directed self-checking bench for instr_fetch_unit with a small
//            behavioural flash (programmable wait states).
// Revision : 1.0  initial release
// ============================================================================
module tb_instr_fetch_unit;

`ifdef IFU_PREFETCH_EN
    localparam int c_GAP = 0;
`else
    localparam int c_GAP = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        flash_req;
    logic [7:0]  flash_addr;
    logic        flash_ack;
    logic [11:0] flash_data;
    logic [11:0] instruction_bus;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  pc_out;
    logic        jmp_en;
    logic [7:0]  jmp_target;

    logic [3:0]  r_wait_st;
    logic [3:0]  r_wait_cnt = 4'd0;
    logic        r_force_ack;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .flash_req       (flash_req),
        .flash_addr      (flash_addr),
        .flash_ack       (flash_ack),
        .flash_data      (flash_data),
        .instruction_bus (instruction_bus),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .pc_out          (pc_out),
        .jmp_en          (jmp_en),
        .jmp_target      (jmp_target)
    );

    function automatic logic [11:0] rom(input logic [7:0] a);
        case (a)
            8'h00:   rom = 12'h341;
            8'h01:   rom = 12'h012;
            8'h02:   rom = 12'h524;
            8'h03:   rom = 12'h000;
            default: rom = {4'h8, a};
        endcase
    endfunction

    // Flash: ack once the request has waited r_wait_st cycles; r_force_ack
    // injects a spurious strobe.
    always_comb begin
        flash_ack  = (flash_req && (r_wait_cnt >= r_wait_st)) || r_force_ack;
        flash_data = r_force_ack ? 12'hABC : rom(flash_addr);
    end

    always @(posedge clk) begin
        if (!flash_req || flash_ack) r_wait_cnt <= 4'd0;
        else                         r_wait_cnt <= r_wait_cnt + 4'd1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a valid head, check it, then let it retire.
    task automatic deliver(input string tag, input logic [7:0] pc,
                           input logic [11:0] w, input int gap);
        int n = 0;
        while (!instr_valid && n < 10) begin
            tick();
            n++;
        end
        check({tag, " valid"}, 16'(instr_valid), 16'd1);
        check({tag, " pc"}, 16'(pc_out), 16'(pc));
        check({tag, " word"}, 16'(instruction_bus), 16'(w));
        if (gap >= 0) check({tag, " gap"}, 16'(n), 16'(gap));
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; instr_ready = 1'b0; jmp_en = 1'b0; jmp_target = 8'h00;
        r_wait_st = 4'd0; r_force_ack = 1'b0;

        // ---- reset ----
        tick(); tick(); tick();
        check("rst req",   16'(flash_req),       16'd0);
        check("rst valid", 16'(instr_valid),     16'd0);
        check("rst bus",   16'(instruction_bus), 16'h000);
        check("rst pc",    16'(pc_out),          16'h00);
        check("rst addr",  16'(flash_addr),      16'h00);

        // release; a stray ack while idle must be ignored
        rst = 1'b0; r_force_ack = 1'b1;
        tick();
        r_force_ack = 1'b0;
        check("start req",   16'(flash_req),   16'd1);
        check("start addr",  16'(flash_addr),  16'h00);
        check("start valid", 16'(instr_valid), 16'd0);

        // ---- core stalled from start ----
        tick();
        check("stall1 valid", 16'(instr_valid),     16'd1);
        check("stall1 bus",   16'(instruction_bus), 16'h341);
        check("stall1 pc",    16'(pc_out),          16'h00);
`ifdef IFU_PREFETCH_EN
        check("stall1 req",   16'(flash_req),  16'd1);
        check("stall1 addr",  16'(flash_addr), 16'h01);
`else
        check("stall1 req",   16'(flash_req),  16'd0);
`endif
        tick();
        check("stall2 req", 16'(flash_req),       16'd0);
        check("stall2 bus", 16'(instruction_bus), 16'h341);
        r_force_ack = 1'b1;
        tick();
        r_force_ack = 1'b0;
        check("stall3 req", 16'(flash_req),       16'd0);
        check("stall3 bus", 16'(instruction_bus), 16'h341);
        tick();
        check("stall4 pc",  16'(pc_out),          16'h00);

        // ---- release stall: sequential stream ----
        instr_ready = 1'b1;
        deliver("seq0", 8'h00, 12'h341, -1);
        deliver("seq1", 8'h01, 12'h012, c_GAP);
        deliver("seq2", 8'h02, 12'h524, c_GAP);
        deliver("seq3", 8'h03, 12'h000, c_GAP);

        // ---- jump during a slow outstanding request (DRAIN) ----
        rst = 1'b1; r_wait_st = 4'd2;
        tick();
        check("rst2 req", 16'(flash_req), 16'd0);
        rst = 1'b0;
        tick();
        check("drn req0",  16'(flash_req),  16'd1);
        check("drn addr0", 16'(flash_addr), 16'h00);
        jmp_en = 1'b1; jmp_target = 8'h20;
        tick();
        check("drn addr1",  16'(flash_addr),  16'h00);
        check("drn valid1", 16'(instr_valid), 16'd0);
        jmp_target = 8'h40;   // newer redirect replaces the first one
        tick();
        jmp_en = 1'b0;
        check("drn req2",  16'(flash_req),  16'd1);
        check("drn addr2", 16'(flash_addr), 16'h00);
        tick();
        check("drn addr3",  16'(flash_addr),  16'h40);
        check("drn valid3", 16'(instr_valid), 16'd0);
        deliver("drn out", 8'h40, 12'h840, -1);

        // ---- jump in the same cycle as an ack ----
        r_wait_st = 4'd0;
        n = 0;
        while (!flash_req && n < 10) begin
            tick();
            n++;
        end
        check("ackj req", 16'(flash_req), 16'd1);
        jmp_en = 1'b1; jmp_target = 8'h10;
        tick();
        jmp_en = 1'b0;
        check("ackj valid", 16'(instr_valid), 16'd0);
        check("ackj req1",  16'(flash_req),   16'd1);
        check("ackj addr",  16'(flash_addr),  16'h10);
        deliver("ackj out", 8'h10, 12'h810, -1);

        // ---- PC wrap ----
        jmp_en = 1'b1; jmp_target = 8'hFF;
        tick();
        jmp_en = 1'b0;
        check("wrap addr0",  16'(flash_addr),  16'hFF);
        check("wrap valid0", 16'(instr_valid), 16'd0);
        tick();
        check("wrap addr1",  16'(flash_addr),  16'h00);
        deliver("wrapFF", 8'hFF, 12'h8FF, -1);
        deliver("wrap00", 8'h00, 12'h341, c_GAP);
        deliver("wrap01", 8'h01, 12'h012, c_GAP);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
